// File: rtl/csi_mode_parser_if.sv
// Types and byte/command interface for the CSI mode-sequence parser.
// The slave side is the parser; the master side feeds bytes and receives commands.
package csi_mode_parser_pkg;
  typedef enum logic [2:0] {
    INIT_PN, EMIT_PN, SETMODE, RESETMODE, SETDEC, RESETDEC
  } CommandsType;

  typedef struct packed {
    logic [7:0] Pns;
  } Param_t;
endpackage

interface csi_mode_parser_if;
  import csi_mode_parser_pkg::*;

  logic        dataReady;
  logic [7:0]  data;
  logic        inReady;
  logic        commandReady;
  CommandsType commandType;
  Param_t      param;

  modport master (
    output dataReady, data,
    input  inReady, commandReady, commandType, param
  );

  modport slave (
    input  dataReady, data,
    output inReady, commandReady, commandType, param
  );
endinterface

// File: rtl/csi_mode_parser.sv
// Parses ESC [ ... h/l mode sequences byte by byte and strobes one command per
// emitted field, throttling input so strobes are at least 3 cycles apart.
module csi_mode_parser
  import csi_mode_parser_pkg::*;
#(
  parameter int MAX_PARAMS = 16
) (
  input  logic             clk,
  input  logic             rst,
  csi_mode_parser_if.slave bus
);

  localparam int CW = $clog2(MAX_PARAMS + 1);

  typedef enum logic [2:0] {
    GROUND, ESCAPE, CSI_ENTRY, CSI_PARAM, CSI_IGNORE
  } state_t;

  state_t      state, nextState;
  logic [7:0]  acc, nextAcc;
  logic [CW-1:0] cnt, nextCnt;
  logic        dec, nextDec;
  logic        emit;
  CommandsType emitType;
  logic [7:0]  emitPns;

  logic        inReadyR, cmdReadyR, coolDown;
  CommandsType cmdTypeR;
  Param_t      paramR;

  logic [7:0]  b;
  logic        isFinal, isDigit, isIgnoreTrig;

  function automatic logic [7:0] satDigit(input logic [7:0] a, input logic [3:0] d);
    logic [11:0] s;
    s = {4'b0, a} * 12'd10 + {8'b0, d};
    return (s > 12'd255) ? 8'd255 : s[7:0];
  endfunction

  assign b            = bus.data;
  assign isFinal      = (b >= 8'h40) && (b <= 8'h7E);
  assign isDigit      = (b >= 8'h30) && (b <= 8'h39);
  assign isIgnoreTrig = (b == 8'h3F) || ((b >= 8'h20) && (b <= 8'h2F)) ||
                        (b == 8'h3A) || ((b >= 8'h3C) && (b <= 8'h3E));

  always_comb begin
    nextState = state;
    nextAcc   = acc;
    nextCnt   = cnt;
    nextDec   = dec;
    emit      = 1'b0;
    emitType  = INIT_PN;
    emitPns   = 8'd0;
    if (b == 8'h18 || b == 8'h1A) begin
      nextState = GROUND;
    end else if (b == 8'h1B) begin
      nextState = ESCAPE;
    end else begin
      case (state)
        GROUND: nextState = GROUND;
        ESCAPE: begin
          if (b == 8'h5B) begin
            nextState = CSI_ENTRY;
            nextAcc   = 8'd0;
            nextCnt   = '0;
            nextDec   = 1'b0;
            emit      = 1'b1;
          end else begin
            nextState = GROUND;
          end
        end
        CSI_ENTRY, CSI_PARAM: begin
          // A leading '?' selects DEC private modes; anywhere else it spoils the sequence.
          if (state == CSI_ENTRY && b == 8'h3F) begin
            nextDec = 1'b1;
          end else if (isDigit) begin
            nextAcc   = satDigit(acc, b[3:0]);
            nextState = CSI_PARAM;
          end else if (b == 8'h3B) begin
            nextState = CSI_PARAM;
            nextAcc   = 8'd0;
            if (cnt < CW'(MAX_PARAMS)) begin
              emit     = 1'b1;
              emitType = EMIT_PN;
              emitPns  = acc;
              nextCnt  = cnt + CW'(1);
            end
          end else if (b == 8'h68) begin
            emit      = 1'b1;
            emitType  = dec ? SETDEC : SETMODE;
            emitPns   = acc;
            nextState = GROUND;
          end else if (b == 8'h6C) begin
            emit      = 1'b1;
            emitType  = dec ? RESETDEC : RESETMODE;
            emitPns   = acc;
            nextState = GROUND;
          end else if (isFinal) begin
            nextState = GROUND;
          end else if (isIgnoreTrig) begin
            nextState = CSI_IGNORE;
          end
        end
        CSI_IGNORE: if (isFinal) nextState = GROUND;
        default:    nextState = GROUND;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= GROUND;
      acc       <= 8'd0;
      cnt       <= '0;
      dec       <= 1'b0;
      cmdReadyR <= 1'b0;
      cmdTypeR  <= INIT_PN;
      paramR    <= '0;
      inReadyR  <= 1'b1;
      coolDown  <= 1'b0;
    end else begin
      // inReady stays low through the strobe cycle and the one after it.
      if (cmdReadyR) begin
        cmdReadyR <= 1'b0;
        coolDown  <= 1'b1;
      end else if (coolDown) begin
        coolDown <= 1'b0;
        inReadyR <= 1'b1;
      end
      if (bus.dataReady && inReadyR) begin
        state <= nextState;
        acc   <= nextAcc;
        cnt   <= nextCnt;
        dec   <= nextDec;
        if (emit) begin
          cmdReadyR  <= 1'b1;
          cmdTypeR   <= emitType;
          paramR.Pns <= emitPns;
          inReadyR   <= 1'b0;
        end
      end
    end
  end

  assign bus.inReady      = inReadyR;
  assign bus.commandReady = cmdReadyR;
  assign bus.commandType  = cmdTypeR;
  assign bus.param        = paramR;

endmodule

// File: tb/tb_csi_mode_parser.sv
// Randomized and directed bench for csi_mode_parser with a queue-based scoreboard.
module tb_csi_mode_parser;
  import csi_mode_parser_pkg::*;

  localparam int MAXP = 4;

  typedef struct {
    CommandsType t;
    logic [7:0]  p;
  } exp_t;

  logic clk;
  logic rst;
  csi_mode_parser_if bus ();

  csi_mode_parser #(.MAX_PARAMS(MAXP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t expQ[$];

  // reference model state
  bit mEsc, mCsi, mIgnore, mStarted, mDec;
  int mAcc, mCnt;

  // monitor state
  int          lastStrobe = -100;
  bit          haveHeld   = 0;
  CommandsType heldType;
  logic [7:0]  heldPns;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void pushExp(CommandsType t, int p);
    exp_t e;
    e.t = t;
    e.p = 8'(p);
    expQ.push_back(e);
  endfunction

  function automatic void modelReset();
    mEsc = 0; mCsi = 0; mIgnore = 0; mStarted = 0; mDec = 0;
    mAcc = 0; mCnt = 0;
  endfunction

  function automatic void modelByte(logic [7:0] b);
    bit fin;
    fin = (b >= 8'h40 && b <= 8'h7E);
    if (b == 8'h18 || b == 8'h1A) begin mEsc = 0; mCsi = 0; return; end
    if (b == 8'h1B) begin mEsc = 1; mCsi = 0; return; end
    if (mEsc) begin
      mEsc = 0;
      if (b == "[") begin
        mCsi = 1; mIgnore = 0; mStarted = 0; mDec = 0; mAcc = 0; mCnt = 0;
        pushExp(INIT_PN, 0);
      end
      return;
    end
    if (!mCsi) return;
    if (mIgnore) begin if (fin) mCsi = 0; return; end
    if (b == "?" && !mStarted) begin mDec = 1; return; end
    if (b >= "0" && b <= "9") begin
      mAcc = mAcc * 10 + int'(b - "0");
      if (mAcc > 255) mAcc = 255;
      mStarted = 1;
      return;
    end
    if (b == ";") begin
      if (mCnt < MAXP) pushExp(EMIT_PN, mAcc);
      mAcc = 0; mCnt++; mStarted = 1;
      return;
    end
    if (b == "h") begin pushExp(mDec ? SETDEC : SETMODE, mAcc); mCsi = 0; return; end
    if (b == "l") begin pushExp(mDec ? RESETDEC : RESETMODE, mAcc); mCsi = 0; return; end
    if (fin) begin mCsi = 0; return; end
    if (b == "?" || (b >= 8'h20 && b <= 8'h2F) || b == 8'h3A || (b >= 8'h3C && b <= 8'h3E))
      mIgnore = 1;
  endfunction

  // Monitor: pops the scoreboard on every strobe and checks spacing and hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.commandReady) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got type=%0d pns=%0d, required no strobe",
                   bus.commandType, bus.param.Pns);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          if (bus.commandType !== e.t || bus.param.Pns !== e.p) begin
            fails++;
            $display("FAIL strobe_value: got type=%0d pns=%0d, required type=%0d pns=%0d",
                     bus.commandType, bus.param.Pns, e.t, e.p);
          end
        end
        tests++;
        if (bus.inReady !== 1'b0) begin
          fails++;
          $display("FAIL inready_during_strobe: got %b, required 0", bus.inReady);
        end
        if (lastStrobe >= 0) begin
          tests++;
          if (cyc - lastStrobe < 3) begin
            fails++;
            $display("FAIL strobe_spacing: got %0d cycles, required >= 3", cyc - lastStrobe);
          end
        end
        lastStrobe = cyc;
        haveHeld   = 1;
        heldType   = bus.commandType;
        heldPns    = bus.param.Pns;
      end else if (haveHeld) begin
        tests++;
        if (bus.commandType !== heldType || bus.param.Pns !== heldPns) begin
          fails++;
          $display("FAIL output_hold: got type=%0d pns=%0d, required type=%0d pns=%0d",
                   bus.commandType, bus.param.Pns, heldType, heldPns);
        end
      end
    end
  end

  task automatic checkResetState(string tag);
    tests++;
    if (bus.commandReady !== 1'b0 || bus.inReady !== 1'b1 ||
        bus.commandType !== INIT_PN || bus.param.Pns !== 8'd0) begin
      fails++;
      $display("FAIL reset_state_%s: got cr=%b ir=%b type=%0d pns=%0d, required cr=0 ir=1 type=0 pns=0",
               tag, bus.commandReady, bus.inReady, bus.commandType, bus.param.Pns);
    end
  endtask

  // Called at negedge+1; pulses reset asynchronously before the next posedge.
  task automatic pulseReset(string tag);
    #1 rst = 1;
    #1 checkResetState(tag);
    #1 rst = 0;
    modelReset();
    expQ.delete();
    haveHeld   = 0;
    lastStrobe = -100;
    @(negedge clk); #1;
    checkResetState({tag, "_after"});
  endtask

  task automatic sendByte(logic [7:0] b);
    bit ok;
    ok = 0;
    bus.data      = b;
    bus.dataReady = 1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.inReady) ok = 1;
      @(posedge clk);
      if (ok) modelByte(b);
      @(negedge clk); #1;
    end
    bus.dataReady = 0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: byte %02h not accepted within 20 cycles, required acceptance", b);
    end
  endtask

  task automatic idle(int n);
    bus.dataReady = 0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic sendStr(string s, int gap);
    for (int i = 0; i < s.len(); i++) begin
      sendByte(s[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  function automatic logic [7:0] randByte();
    case ($urandom_range(0, 15))
      0, 14:   return 8'h1B;
      1, 15:   return "[";
      2:       return "?";
      3, 4, 5: return 8'(8'h30 + $urandom_range(0, 9));
      6:       return ";";
      7:       return "h";
      8:       return "l";
      9:       return "m";
      10:      return ($urandom_range(0, 1) != 0) ? 8'h18 : 8'h1A;
      11:      return 8'(8'h20 + $urandom_range(0, 15));
      12:      return 8'(8'h3A + $urandom_range(0, 4));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    bus.dataReady = 0;
    bus.data = 8'h00;
    modelReset();
    #3 checkResetState("initial");
    @(negedge clk); #1;
    rst = 0;

    sendByte(8'h1B); sendStr("[?25h", 1); idle(4);
    sendByte(8'h1B); sendStr("[4;20l", 2); idle(4);
    sendByte(8'h1B); sendStr("[999h", 0); idle(4);
    sendByte(8'h1B); sendStr("[1", 0); sendByte(8'h18); sendStr("h", 0); idle(3);
    sendByte(8'h1B); sendStr("[1$h", 0); idle(4);
    sendByte(8'h1B); sendStr("[;;h", 0); idle(4);
    sendByte(8'h1B); sendStr("[1;2;3;4;5;6h", 0); idle(4);
    sendByte(8'h1B); sendStr("[?3l", 1); idle(4);
    sendByte(8'h1B); sendStr("[1?2h", 0); idle(4);
    sendByte(8'h1B); sendByte(8'h1B); sendStr("[h", 0); idle(4);
    sendByte(8'h1B); sendStr("[5", 0); sendByte(8'h1A); sendStr("[2l", 0); idle(4);

    sendByte(8'h1B); sendStr("[6", 0); idle(4);
    pulseReset("mid_sequence");
    sendStr(";h", 1); idle(4);

    sendByte(8'h1B); sendStr("[7h", 0);
    pulseReset("during_strobe");
    idle(2);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) sendByte(8'h1B);
      if ($urandom_range(0, 3) == 0) sendByte("[");
      sendByte(randByte());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(10);

    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL pending_expected: got %0d unmatched expected strobes, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csi_mode_parser.md
CSI_MODE_PARSER -- requirements
Module: csi_mode_parser

Interface
REQ-001 SHALL have parameter MAX_PARAMS, default 16, maximum number of Pn fields emitted per sequence; fields beyond this are parsed but not emitted.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port dataReady  input  1  incoming byte valid.
REQ-005 SHALL have port data  input  8  incoming byte, ASCII.
REQ-006 SHALL have port inReady  output  1  byte accepted on a cycle where dataReady && inReady.
REQ-007 SHALL have port commandReady  output  1  one-cycle command strobe to the mode-control stage.
REQ-008 SHALL have port commandType  output  CommandsType  command code, one of INIT_PN, EMIT_PN, SETMODE, RESETMODE, SETDEC, RESETDEC.
REQ-009 SHALL have port param  output  Param_t  param.Pns (8 bits) carries the current numeric field.

Function
REQ-010 SHALL implement FSM states GROUND, ESCAPE, CSI_ENTRY, CSI_PARAM, CSI_IGNORE; all transitions occur only on accepted bytes.
REQ-011 GROUND: 0x1B -> ESCAPE; all other bytes are consumed with no command.
REQ-012 ESCAPE: '[' (0x5B) -> CSI_ENTRY, clear accumulator, param count and dec flag, emit INIT_PN; 0x1B stays in ESCAPE; any other byte -> GROUND.
REQ-013 CSI_ENTRY: '?' (0x3F) sets dec flag, stays in CSI_ENTRY, no command; digit or ';' or final byte is handled as in CSI_PARAM and moves to CSI_PARAM (or GROUND on final).
REQ-014 CSI_PARAM digit '0'-'9': acc = acc*10 + digit, saturating at 255, no command.
REQ-015 CSI_PARAM ';': emit EMIT_PN with Pns = acc (0 if field empty), then clear acc and increment param count; no emit once count >= MAX_PARAMS.
REQ-016 Final 'h' (0x68): emit SETDEC if dec flag set, else SETMODE, with Pns = acc; -> GROUND.
REQ-017 Final 'l' (0x6C): emit RESETDEC if dec flag set, else RESETMODE, with Pns = acc; -> GROUND.
REQ-018 Any other final byte 0x40-0x7E: no command, -> GROUND.
REQ-019 '?' after the first parameter byte, or intermediates 0x20-0x2F, or 0x3A/0x3C-0x3E: -> CSI_IGNORE.
REQ-020 CSI_IGNORE: consume bytes without command until a final byte 0x40-0x7E, then -> GROUND.
REQ-021 In any state, CAN (0x18) or SUB (0x1A) -> GROUND with no command; 0x1B -> ESCAPE, abandoning the current sequence.
REQ-022 commandReady SHALL be registered: a byte accepted in cycle N that emits drives commandReady high in cycle N+1 only.
REQ-023 commandType and param SHALL be held stable from the strobe cycle until the next strobe; the downstream stage samples commandType one cycle after the strobe.
REQ-024 inReady SHALL be low in the cycle commandReady is high and in the following cycle, guaranteeing at least 2 idle cycles between strobes; otherwise inReady is high.
REQ-025 Bytes presented while inReady is low SHALL NOT be consumed; the source holds them.

Reset
REQ-026 On rst, regardless of clk: state = GROUND, acc = 0, count = 0, dec flag = 0, commandReady = 0, commandType = INIT_PN, param = 0, inReady = 1.
REQ-027 Reset asserted mid-sequence SHALL discard the partial sequence; the first byte after release is parsed from GROUND.

Verification
REQ-028 Bytes ESC [ ? 2 5 h -> strobes INIT_PN, then SETDEC with Pns = 25; no other strobes; state returns to GROUND.
REQ-029 Bytes ESC [ 4 ; 2 0 l -> INIT_PN, EMIT_PN Pns = 4, RESETMODE Pns = 20; each strobe is 1 cycle wide, with >= 2 cycles between strobes.
REQ-030 Bytes ESC [ 9 9 9 h -> SETMODE with Pns = 255 (saturated).
REQ-031 Bytes ESC [ 1 CAN h, then ESC [ 1 $ h -> only the two INIT_PN strobes; no SETMODE in either case.
REQ-032 dataReady held high continuously with ESC [ ; ; h -> inReady drops for 2 cycles after each strobe; strobes are INIT_PN, EMIT_PN 0, EMIT_PN 0, SETMODE 0; no byte is lost.
REQ-033 rst pulsed after ESC [ 6, then bytes ; h -> no command is emitted.
